// File: rtl/UART_pkg.sv
// Shared types, line levels and frame helpers for the parametrised UART transmitter.
package UART_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'b000,
    PAR_EVEN  = 3'b100,
    PAR_ODD   = 3'b101,
    PAR_MARK  = 3'b110,
    PAR_SPACE = 3'b111
  } parity_mode_e;

  typedef enum logic [1:0] {
    STOP_1   = 2'b00,
    STOP_1P5 = 2'b01,
    STOP_2   = 2'b10
  } stop_bits_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_e;

  localparam logic [3:0] MIN_DATA_LEN = 4'd5;
  localparam logic       TX_IDLE      = 1'b1;
  localparam logic       TX_START     = 1'b0;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    logic [3:0] res;
    if (len < MIN_DATA_LEN) begin
      res = MIN_DATA_LEN;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

  // Parity over the low `len` bits only; bits above the frame length never count.
  function automatic logic calc_parity(input logic [15:0] data, input logic [3:0] len,
                                       input parity_mode_e mode);
    logic x;
    logic res;
    x = 1'b0;
    for (int i = 0; i < 16; i++) begin
      x = x ^ (data[i] & (i < int'(len)));
    end
    case (mode)
      PAR_EVEN:  res = x;
      PAR_ODD:   res = ~x;
      PAR_MARK:  res = 1'b1;
      PAR_SPACE: res = 1'b0;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is taken only alongside a pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]  ZERO_CNT = {(AW+1){1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Accept decisions for this cycle's push and pop.
  always_comb begin
    pop_ok_s  = pop && (count_r != ZERO_CNT);
    push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_CNT;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == ZERO_CNT);
  assign count   = count_r;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: TX FIFO feeding a frame FSM paced by an oversampling tick,
// with configurable length, parity, stop bits, CTS gating and a timed break.
module uart_tx_param
  import UART_pkg::*;
#(
  parameter int DATA_W       = 9,
  parameter int FIFO_DEPTH   = 16,
  parameter int OVS          = 16,
  parameter int BREAK_CYCLES = 1000000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ov_baud_rt_i,
  input  logic [DATA_W-1:0]             data_tx_i,
  input  logic                          tx_fifo_write_i,
  input  logic [3:0]                    data_len_i,
  input  logic [2:0]                    parity_mode_i,
  input  logic [1:0]                    stop_bits_i,
  input  logic                          cts_n_i,
  input  logic                          cts_en_i,
  input  logic                          break_req_i,
  output logic                          tx_o,
  output logic                          tx_done_o,
  output logic                          break_done_o,
  output logic                          busy_o,
  output logic                          tx_fifo_empty_o,
  output logic                          tx_fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count_o,
  output logic                          overflow_o
);

  localparam int             TW       = $clog2(2*OVS);
  localparam int             BW       = $clog2(BREAK_CYCLES+1);
  localparam logic [TW-1:0]  LAST_1   = TW'(OVS-1);
  localparam logic [TW-1:0]  LAST_1P5 = TW'((3*OVS)/2-1);
  localparam logic [TW-1:0]  LAST_2   = TW'(2*OVS-1);
  localparam logic [BW-1:0]  BRK_LAST = BW'(BREAK_CYCLES-1);
  localparam logic [3:0]     MAX_LEN  = 4'(DATA_W);

  logic [DATA_W-1:0]         fifo_dout_s;
  logic                      fifo_empty_s;
  logic                      fifo_full_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
  logic                      pop_s;
  logic                      can_start_s;
  logic                      bit_end_s;
  logic                      line_s;
  logic [TW-1:0]             last_tick_s;
  logic [3:0]                start_len_s;
  parity_mode_e              start_par_s;
  stop_bits_e                start_stop_s;

  tx_state_e                 state_r;
  logic                      tx_r;
  logic                      done_r;
  logic                      brk_done_r;
  logic                      ovf_r;
  logic [TW-1:0]             tick_r;
  logic [3:0]                bit_r;
  logic [BW-1:0]             brk_r;
  logic [DATA_W-1:0]         shreg_r;
  logic [3:0]                len_r;
  parity_mode_e              par_mode_r;
  stop_bits_e                stop_r;
  logic                      par_bit_r;

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (tx_fifo_write_i),
    .pop     (pop_s),
    .wr_data (data_tx_i),
    .rd_data (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Frame configuration as it would be latched if a word were popped now.
  always_comb begin
    start_len_s = clamp_len(data_len_i, MAX_LEN);
    if (parity_mode_i[2]) start_par_s = parity_mode_e'(parity_mode_i);
    else                  start_par_s = PAR_NONE;
    if (stop_bits_i[1]) start_stop_s = STOP_2;
    else                start_stop_s = stop_bits_e'(stop_bits_i);
  end

  // Bit timing, pop decision and the line level implied by the current state.
  always_comb begin
    can_start_s = !fifo_empty_s && (!cts_en_i || !cts_n_i);
    last_tick_s = LAST_1;
    if (state_r == ST_STOP) begin
      case (stop_r)
        STOP_1:   last_tick_s = LAST_1;
        STOP_1P5: last_tick_s = LAST_1P5;
        STOP_2:   last_tick_s = LAST_2;
        default:  last_tick_s = LAST_2;
      endcase
    end else begin
      last_tick_s = LAST_1;
    end
    if (ov_baud_rt_i && (state_r inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
        && (tick_r == last_tick_s)) bit_end_s = 1'b1;
    else bit_end_s = 1'b0;
    // Popping straight out of STOP gives back-to-back frames without an idle bit.
    if (state_r == ST_IDLE)                 pop_s = can_start_s;
    else if (state_r == ST_STOP && bit_end_s) pop_s = can_start_s;
    else                                     pop_s = 1'b0;
    case (state_r)
      ST_IDLE:   line_s = TX_IDLE;
      ST_START:  line_s = TX_START;
      ST_DATA:   line_s = shreg_r[0];
      ST_PARITY: line_s = par_bit_r;
      ST_STOP:   line_s = TX_IDLE;
      ST_BREAK:  line_s = 1'b0;
      default:   line_s = TX_IDLE;
    endcase
  end

  // Frame FSM with tick, bit and break counters and registered line/pulse outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      tx_r       <= TX_IDLE;
      done_r     <= 1'b0;
      brk_done_r <= 1'b0;
      tick_r     <= {TW{1'b0}};
      bit_r      <= 4'd0;
      brk_r      <= {BW{1'b0}};
      shreg_r    <= {DATA_W{1'b0}};
      len_r      <= MIN_DATA_LEN;
      par_mode_r <= PAR_NONE;
      stop_r     <= STOP_1;
      par_bit_r  <= 1'b0;
    end else begin
      tx_r       <= line_s;
      done_r     <= 1'b0;
      brk_done_r <= 1'b0;
      if (pop_s || bit_end_s) tick_r <= {TW{1'b0}};
      else if (ov_baud_rt_i && (state_r inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}))
        tick_r <= tick_r + TW'(1);
      else tick_r <= tick_r;
      if (pop_s) begin
        shreg_r    <= fifo_dout_s;
        len_r      <= start_len_s;
        par_mode_r <= start_par_s;
        stop_r     <= start_stop_s;
        par_bit_r  <= calc_parity(16'(fifo_dout_s), start_len_s, start_par_s);
        bit_r      <= 4'd0;
      end
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r <= ST_START;
          end else if (break_req_i && fifo_empty_s) begin
            state_r <= ST_BREAK;
            brk_r   <= {BW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          if (bit_end_s) state_r <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_end_s) begin
            shreg_r <= {1'b0, shreg_r[DATA_W-1:1]};
            if (bit_r == len_r - 4'd1) begin
              bit_r   <= 4'd0;
              state_r <= (par_mode_r == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_r <= bit_r + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end_s) state_r <= ST_STOP;
        end
        ST_STOP: begin
          if (bit_end_s) begin
            done_r  <= 1'b1;
            state_r <= pop_s ? ST_START : ST_IDLE;
          end
        end
        ST_BREAK: begin
          if (brk_r == BRK_LAST) begin
            brk_done_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            brk_r <= brk_r + BW'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Dropped-write pulse: full with no pop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_r <= 1'b0;
    else       ovf_r <= tx_fifo_write_i && fifo_full_s && !pop_s;
  end

  assign tx_o            = tx_r;
  assign tx_done_o       = done_r;
  assign break_done_o    = brk_done_r;
  assign busy_o          = (state_r != ST_IDLE);
  assign tx_fifo_empty_o = fifo_empty_s;
  assign tx_fifo_full_o  = fifo_full_s;
  assign tx_fifo_count_o = fifo_count_s;
  assign overflow_o      = ovf_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame waveforms, config latching, FIFO limits, break, reset.
module tb_uart_tx_param;

  localparam int DATA_W = 9, FIFO_DEPTH = 4, OVS = 16, BREAK_CYCLES = 100;

  logic clk, rst_i, ov_baud_rt_i, tx_fifo_write_i, cts_n_i, cts_en_i, break_req_i;
  logic [DATA_W-1:0] data_tx_i;
  logic [3:0] data_len_i;
  logic [2:0] parity_mode_i;
  logic [1:0] stop_bits_i;
  logic tx_o, tx_done_o, break_done_o, busy_o, tx_fifo_empty_o, tx_fifo_full_o, overflow_o;
  logic [$clog2(FIFO_DEPTH):0] tx_fifo_count_o;
  int pass_cnt = 0, total_cnt = 0;

  uart_tx_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OVS(OVS), .BREAK_CYCLES(BREAK_CYCLES)) dut (
    .clk_i(clk), .rst_i(rst_i), .ov_baud_rt_i(ov_baud_rt_i), .data_tx_i(data_tx_i),
    .tx_fifo_write_i(tx_fifo_write_i), .data_len_i(data_len_i), .parity_mode_i(parity_mode_i),
    .stop_bits_i(stop_bits_i), .cts_n_i(cts_n_i), .cts_en_i(cts_en_i), .break_req_i(break_req_i),
    .tx_o(tx_o), .tx_done_o(tx_done_o), .break_done_o(break_done_o), .busy_o(busy_o),
    .tx_fifo_empty_o(tx_fifo_empty_o), .tx_fifo_full_o(tx_fifo_full_o),
    .tx_fifo_count_o(tx_fifo_count_o), .overflow_o(overflow_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_cfg(input logic [3:0] len, input logic [2:0] par, input logic [1:0] stp);
    data_len_i = len; parity_mode_i = par; stop_bits_i = stp;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    data_tx_i = d; tx_fifo_write_i = 1'b1;
    @(negedge clk);
    tx_fifo_write_i = 1'b0;
  endtask

  // Advance negedges until the start bit shows; n = negedges waited.
  task automatic wait_start(input string name, output int n);
    n = 0;
    while (tx_o !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx_o !== 1'b0) begin
      total_cnt++;
      $display("FAIL %s start_timeout: got tx_o=%b expected 0 within 400 clk", name, tx_o);
    end
  endtask

  // Sample one whole frame starting at the current negedge (first start-bit clk).
  task automatic check_frame(input string name, input logic [DATA_W-1:0] data, input int nbits,
                             input bit has_par, input logic par, input int stop_ticks);
    int total, bad, first_bad, done_cnt, done_at, seg;
    logic e, got_b, exp_b;
    total = OVS * (1 + nbits + (has_par ? 1 : 0)) + stop_ticks;
    bad = 0; first_bad = -1; done_cnt = 0; done_at = -1; got_b = 1'b0; exp_b = 1'b0;
    for (int i = 0; i < total; i++) begin
      if (i > 0) @(negedge clk);
      seg = i / OVS;
      if (seg == 0) e = 1'b0;
      else if (seg <= nbits) e = data[seg-1];
      else if (has_par && seg == nbits + 1) e = par;
      else e = 1'b1;
      if (tx_o !== e) begin
        bad++;
        if (first_bad < 0) begin first_bad = i; got_b = tx_o; exp_b = e; end
      end
      if (tx_done_o === 1'b1) begin done_cnt++; done_at = i; end
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL %s waveform: %0d bad clk, first at clk %0d got %b expected %b", name, bad, first_bad, got_b, exp_b);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt != 1 || done_at != total - 1)
      $display("FAIL %s tx_done: got %0d pulses (last at clk %0d) expected 1 at clk %0d", name, done_cnt, done_at, total - 1);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (tx_o !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx_o); else pass_cnt++;
    total_cnt++; if (tx_done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", tx_done_o); else pass_cnt++;
    total_cnt++; if (break_done_o !== 1'b0) $display("FAIL reset_brk_done: got %b expected 0", break_done_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else pass_cnt++;
    total_cnt++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", overflow_o); else pass_cnt++;
    total_cnt++; if (tx_fifo_empty_o !== 1'b1) $display("FAIL reset_empty: got %b expected 1", tx_fifo_empty_o); else pass_cnt++;
    total_cnt++; if (tx_fifo_full_o !== 1'b0) $display("FAIL reset_full: got %b expected 0", tx_fifo_full_o); else pass_cnt++;
    total_cnt++; if (tx_fifo_count_o !== 3'd0) $display("FAIL reset_count: got %0d expected 0", tx_fifo_count_o); else pass_cnt++;
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_8n1;
    int n;
    set_cfg(4'd8, 3'b000, 2'b00);
    push_word(9'h0A5);
    wait_start("8n1", n);
    total_cnt++; if (n != 2) $display("FAIL 8n1_latency: got %0d clk expected 2", n); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL 8n1_busy: got %b expected 1", busy_o); else pass_cnt++;
    total_cnt++; if (tx_fifo_count_o !== 3'd0) $display("FAIL 8n1_count: got %0d expected 0", tx_fifo_count_o); else pass_cnt++;
    check_frame("8n1", 9'h0A5, 8, 1'b0, 1'b0, 16);
    @(negedge clk);
    total_cnt++; if (tx_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL 8n1_idle: got tx=%b busy=%b expected tx=1 busy=0", tx_o, busy_o); else pass_cnt++;
  endtask

  task automatic test_odd_2stop_cfg_latch;
    int n;
    set_cfg(4'd7, 3'b101, 2'b10);
    data_tx_i = 9'h055; tx_fifo_write_i = 1'b1;
    @(negedge clk);
    data_tx_i = 9'h0B3;
    @(negedge clk);
    tx_fifo_write_i = 1'b0;
    wait_start("7o2", n);
    data_len_i = 4'd8;
    check_frame("7o2_f1", 9'h055, 7, 1'b1, 1'b1, 32);
    @(negedge clk);
    check_frame("8o2_f2", 9'h0B3, 8, 1'b1, 1'b0, 32);
    @(negedge clk);
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL 8o2_busy_end: got %b expected 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_mark_1p5_and_clamp;
    int n;
    set_cfg(4'd5, 3'b110, 2'b01);
    push_word(9'h01F);
    wait_start("5m15", n);
    check_frame("5m15", 9'h01F, 5, 1'b1, 1'b1, 24);
    @(negedge clk);
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL 5m15_busy_end: got %b expected 0", busy_o); else pass_cnt++;
    set_cfg(4'd4, 3'b100, 2'b00);
    push_word(9'h0F6);
    wait_start("len4", n);
    check_frame("len4_as5", 9'h0F6, 5, 1'b1, 1'b1, 16);
    @(negedge clk);
    set_cfg(4'd15, 3'b100, 2'b00);
    push_word(9'h1A5);
    wait_start("len15", n);
    check_frame("len15_as9", 9'h1A5, 9, 1'b1, 1'b1, 16);
    @(negedge clk);
  endtask

  task automatic test_fifo_cts;
    int n, ovf_cnt;
    logic [DATA_W-1:0] words [5];
    words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033; words[3] = 9'h044; words[4] = 9'h077;
    set_cfg(4'd8, 3'b000, 2'b00);
    cts_en_i = 1'b1; cts_n_i = 1'b1; ovf_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      data_tx_i = 9'(8'h11 * (i + 1)); tx_fifo_write_i = 1'b1;
      @(negedge clk);
      if (overflow_o === 1'b1) ovf_cnt++;
      if (i == 0) begin
        total_cnt++; if (tx_fifo_count_o !== 3'd1) $display("FAIL fifo_count1: got %0d expected 1", tx_fifo_count_o); else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++; if (tx_fifo_full_o !== 1'b1) $display("FAIL fifo_full4: got %b expected 1", tx_fifo_full_o); else pass_cnt++;
      end
    end
    tx_fifo_write_i = 1'b0;
    @(negedge clk);
    if (overflow_o === 1'b1) ovf_cnt++;
    total_cnt++; if (ovf_cnt != 2) $display("FAIL fifo_ovf_pulses: got %0d expected 2", ovf_cnt); else pass_cnt++;
    total_cnt++; if (tx_fifo_count_o !== 3'd4) $display("FAIL fifo_count4: got %0d expected 4", tx_fifo_count_o); else pass_cnt++;
    total_cnt++; if (tx_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL cts_hold: got tx=%b busy=%b expected tx=1 busy=0", tx_o, busy_o); else pass_cnt++;
    cts_n_i = 1'b0; data_tx_i = 9'h077; tx_fifo_write_i = 1'b1;
    @(negedge clk);
    tx_fifo_write_i = 1'b0;
    total_cnt++; if (overflow_o !== 1'b0 || tx_fifo_count_o !== 3'd4)
      $display("FAIL full_push_pop: got ovf=%b count=%0d expected ovf=0 count=4", overflow_o, tx_fifo_count_o); else pass_cnt++;
    wait_start("fifo", n);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check_frame($sformatf("fifo_f%0d", k), words[k], 8, 1'b0, 1'b0, 16);
    end
    @(negedge clk);
    total_cnt++; if (tx_o !== 1'b1 || tx_fifo_empty_o !== 1'b1)
      $display("FAIL fifo_drained: got tx=%b empty=%b expected tx=1 empty=1", tx_o, tx_fifo_empty_o); else pass_cnt++;
    cts_en_i = 1'b0; cts_n_i = 1'b1;
  endtask

  task automatic test_break;
    int n, lows, bd_cnt, bd_at;
    bit seen_high;
    set_cfg(4'd8, 3'b000, 2'b00);
    data_tx_i = 9'h0C3; tx_fifo_write_i = 1'b1;
    @(negedge clk);
    data_tx_i = 9'h03C;
    @(negedge clk);
    tx_fifo_write_i = 1'b0; break_req_i = 1'b1;
    wait_start("brk", n);
    check_frame("brk_f1", 9'h0C3, 8, 1'b0, 1'b0, 16);
    @(negedge clk);
    check_frame("brk_f2", 9'h03C, 8, 1'b0, 1'b0, 16);
    @(negedge clk);
    total_cnt++; if (tx_o !== 1'b1) $display("FAIL brk_gap: got %b expected 1", tx_o); else pass_cnt++;
    lows = 0; bd_cnt = 0; bd_at = -1; seen_high = 1'b0;
    for (int i = 0; i < 300 && !seen_high; i++) begin
      @(negedge clk);
      break_req_i = 1'b0;
      if (tx_o === 1'b0) lows++;
      else seen_high = 1'b1;
      if (break_done_o === 1'b1) begin bd_cnt++; bd_at = lows; end
    end
    total_cnt++; if (lows != 100 || !seen_high) $display("FAIL brk_len: got %0d low clk expected 100", lows); else pass_cnt++;
    total_cnt++; if (bd_cnt != 1 || bd_at != 100)
      $display("FAIL brk_done: got %0d pulses at low clk %0d expected 1 at 100", bd_cnt, bd_at); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL brk_busy_end: got %b expected 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    int n, lows, dones;
    set_cfg(4'd8, 3'b000, 2'b00);
    for (int i = 0; i < 3; i++) begin
      data_tx_i = (i == 0) ? 9'h00F : ((i == 1) ? 9'h0F0 : 9'h05A);
      tx_fifo_write_i = 1'b1;
      @(negedge clk);
    end
    tx_fifo_write_i = 1'b0;
    wait_start("rst", n);
    check_frame("rst_f1", 9'h00F, 8, 1'b0, 1'b0, 16);
    @(negedge clk);
    repeat (3 * OVS) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    total_cnt++; if (tx_o !== 1'b1) $display("FAIL rst_mid_tx: got %b expected 1", tx_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy_o); else pass_cnt++;
    total_cnt++; if (tx_fifo_count_o !== 3'd0 || tx_fifo_empty_o !== 1'b1)
      $display("FAIL rst_mid_fifo: got count=%0d empty=%b expected 0/1", tx_fifo_count_o, tx_fifo_empty_o); else pass_cnt++;
    total_cnt++; if (tx_done_o !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", tx_done_o); else pass_cnt++;
    rst_i = 1'b0;
    lows = 0; dones = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
      if (tx_done_o === 1'b1) dones++;
    end
    total_cnt++; if (lows != 0 || dones != 0)
      $display("FAIL rst_mid_quiet: got %0d low clk, %0d done pulses expected 0/0", lows, dones); else pass_cnt++;
  endtask

  initial begin
    rst_i = 1'b1; ov_baud_rt_i = 1'b1; tx_fifo_write_i = 1'b0; data_tx_i = '0;
    data_len_i = 4'd8; parity_mode_i = 3'b000; stop_bits_i = 2'b00;
    cts_n_i = 1'b1; cts_en_i = 1'b0; break_req_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_odd_2stop_cfg_latch();
    test_mark_1p5_and_clamp();
    test_fifo_cts();
    test_break();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
